// File: rtl/dmem_store_buffer_pkg.sv
// dmem_store_buffer_pkg
//   Shared definitions for the data-memory store buffer: default sizes,
//   the load-miss FSM state type and the word-address match helper.
package dmem_store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_WAIT = 2'd2,
    LD_DONE = 2'd3
  } sb_state_e;

  // Two addresses refer to the same word when they differ only in the byte offset.
  function automatic logic word_match(input logic [SB_AW-1:0] a, input logic [SB_AW-1:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// dmem_store_buffer_sb_fifo
//   Circular store queue with per-entry valid bits and a parallel
//   youngest-match lookup used for store-to-load forwarding.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   push_i/push_addr_i/_data_i enqueue at tail (ignored when full)
//   pop_i                     dequeue head (ignored when empty)
//   lookup_addr_i             address searched for forwarding
//   hit_o, hit_data_o         youngest matching entry
//   head_addr_o, head_data_o  oldest entry
//   count_o, full_o, empty_o  occupancy
module dmem_store_buffer_sb_fifo
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_addr_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  input  logic [AW-1:0]          lookup_addr_i,
  output logic                   hit_o,
  output logic [DW-1:0]          hit_data_o,
  output logic [AW-1:0]          head_addr_o,
  output logic [DW-1:0]          head_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;
  logic [PW-1:0]    srch_idx;

  // Occupancy comes from the counter; pointer equality is ambiguous when full.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    srch_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      srch_idx = head_q + PW'(i);
      if (valid_q[srch_idx] && word_match(addr_q[srch_idx], lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[srch_idx];
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posts stores into a small queue, forwards queued data to loads of the
//   same word, sends load misses to memory ahead of queued stores and drains
//   stores in the background.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   core_we_i/core_re_i/core_addr_i/core_wdata_i  memory-stage request
//   core_rdata_o, core_stall_o         load data, pipeline freeze
//   mem_valid_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_ready_i  request port
//   mem_rvalid_i, mem_rdata_i          read response
//   sb_count_o, sb_empty_o             buffer occupancy
//
// state   | meaning
// IDLE    | forward hits, drain stores, issue a miss read when the port is free
// LD_REQ  | read presented, waiting for mem_ready
// LD_WAIT | read accepted, waiting for mem_rvalid
// LD_DONE | captured data on core_rdata_o, stall released for one cycle
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   core_we_i,
  input  logic                   core_re_i,
  input  logic [AW-1:0]          core_addr_i,
  input  logic [DW-1:0]          core_wdata_i,
  output logic [DW-1:0]          core_rdata_o,
  output logic                   core_stall_o,
  output logic                   mem_valid_o,
  output logic                   mem_we_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [DW-1:0]          mem_wdata_o,
  input  logic                   mem_ready_i,
  input  logic                   mem_rvalid_i,
  input  logic [DW-1:0]          mem_rdata_i,
  output logic [$clog2(DEPTH):0] sb_count_o,
  output logic                   sb_empty_o
);

  sb_state_e     state_q, state_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          wr_pend_q, wr_pend_d;
  logic          push, pop, hit, full, empty, load_miss;
  logic [DW-1:0] hit_data, head_data;
  logic [AW-1:0] head_addr;

  dmem_store_buffer_sb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .push_addr_i   (core_addr_i),
    .push_data_i   (core_wdata_i),
    .pop_i         (pop),
    .lookup_addr_i (core_addr_i),
    .hit_o         (hit),
    .hit_data_o    (hit_data),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .count_o       (sb_count_o),
    .full_o        (full),
    .empty_o       (empty)
  );

  assign sb_empty_o = empty;
  assign push       = core_we_i && !full;
  assign load_miss  = core_re_i && !hit;

  always_comb begin
    state_d      = state_q;
    ld_data_d    = ld_data_q;
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    core_stall_o = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A write left waiting on the port must finish before a read may replace it.
        if (load_miss && !wr_pend_q) begin
          mem_valid_o  = 1'b1;
          mem_addr_o   = core_addr_i;
          core_stall_o = 1'b1;
          state_d      = mem_ready_i ? LD_WAIT : LD_REQ;
        end else begin
          if (!empty) begin
            mem_valid_o = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = head_addr;
            mem_wdata_o = head_data;
            pop         = mem_ready_i;
          end
          core_stall_o = load_miss || (core_we_i && full);
        end
      end
      LD_REQ: begin
        mem_valid_o  = 1'b1;
        mem_addr_o   = core_addr_i;
        core_stall_o = 1'b1;
        if (mem_ready_i) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        core_stall_o = 1'b1;
        if (mem_rvalid_i) begin
          ld_data_d = mem_rdata_i;
          state_d   = LD_DONE;
        end
      end
      LD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_pend_d = mem_valid_o && mem_we_o && !mem_ready_i;

  always_comb begin
    core_rdata_o = '0;
    if (state_q == LD_DONE)    core_rdata_o = ld_data_q;
    else if (core_re_i && hit) core_rdata_o = hit_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ld_data_q <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
      wr_pend_q <= wr_pend_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, rst_n;
  logic          core_we, core_re, core_stall;
  logic [31:0]   core_addr, core_wdata, core_rdata;
  logic          mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [CW-1:0] sb_count;
  logic          sb_empty;

  dmem_store_buffer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_we_i(core_we), .core_re_i(core_re), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_rdata_o(core_rdata), .core_stall_o(core_stall),
    .mem_valid_o(mem_valid), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .sb_count_o(sb_count), .sb_empty_o(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending stores in program order, plus the memory image.
  typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
  st_t         q[$];
  logic [31:0] mm [logic [29:0]];

  int          n_cmp = 0, n_bad = 0;
  int          rv_cnt = 0, cur_lat = 1;
  logic [31:0] rv_data;
  bit          prev_wr_wait = 0, prev_rd_wait = 0;
  bit          last_stall, last_push;
  logic [31:0] last_rdata;
  int          stalls;

  always @(posedge clk)
    assert (!(core_we === 1'b1 && core_re === 1'b1))
      else begin n_bad++; $error("FAIL illegal_we_re: observed both high expected exclusive"); end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin n_bad++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return mm.exists(a[31:2]) ? mm[a[31:2]] : ~a;
  endfunction

  function automatic bit rdy_of(input int c, input int p);
    if (p >= 0)  return c == p;
    if (p == -1) return 1'b0;
    if (p == -2) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: inputs other than mem_ready/mem_rvalid already driven.
  task automatic cyc(input bit rdy);
    bit  full_m;
    st_t e;
    mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rv_data; end
    end
    mem_ready = rdy;
    #1;
    last_stall = core_stall;
    last_rdata = core_rdata;
    full_m     = (q.size() == DEPTH);
    last_push  = core_we && !full_m;
    if (core_we)      chk("store_stall", core_stall, full_m);
    if (!core_re)     chk("drain_valid", mem_valid && mem_we, q.size() > 0);
    if (prev_wr_wait) chk("wr_hold", mem_valid && mem_we, 1);
    if (prev_rd_wait) chk("rd_hold", mem_valid && !mem_we, 1);
    if (mem_valid && mem_we) begin
      chk("wr_needs_entry", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("wr_addr", mem_addr, q[0].a);
        chk("wr_data", mem_wdata, q[0].d);
      end
    end
    if (mem_valid && !mem_we) chk("rd_addr", mem_addr, core_addr);
    prev_wr_wait = mem_valid && mem_we && !rdy;
    prev_rd_wait = mem_valid && !mem_we && !rdy;
    if (mem_valid && !mem_we && rdy) begin rv_cnt = cur_lat; rv_data = mem_val(mem_addr); end
    if (mem_valid && mem_we && rdy && q.size() > 0) begin
      mm[q[0].a[31:2]] = q[0].d;
      void'(q.pop_front());
    end
    if (last_push) begin e.a = core_addr; e.d = core_wdata; q.push_back(e); end
    @(posedge clk);
    @(negedge clk);
    chk("sb_count", sb_count, q.size());
    chk("sb_empty", sb_empty, q.size() == 0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int pulse, output int st);
    core_we = 1'b1; core_re = 1'b0; core_addr = a; core_wdata = d; st = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(rdy_of(c, pulse));
      if (last_push) break;
      st++;
    end
    core_we = 1'b0;
    chk("store_accepted", last_push, 1);
  endtask

  task automatic do_load(input logic [31:0] a, input int rdly, input int lat, output int st);
    logic [31:0] exp;
    bit hit = 0, done = 0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[31:2] == a[31:2]) begin exp = q[i].d; hit = 1; break; end
    if (!hit) exp = mem_val(a);
    core_we = 1'b0; core_re = 1'b1; core_addr = a; cur_lat = lat; st = 0;
    for (int c = 0; c < 60; c++) begin
      cyc(rdly < 0 ? rdy_of(0, -3) : (c >= rdly));
      if (!last_stall) begin done = 1; break; end
      st++;
    end
    core_re = 1'b0;
    chk("load_done", done, 1);
    chk("load_data", last_rdata, exp);
    if (hit) chk("hit_no_stall", st, 0);
  endtask

  task automatic idle(input int n, input int pulse);
    core_we = 1'b0; core_re = 1'b0;
    for (int c = 0; c < n; c++) cyc(rdy_of(c, pulse));
  endtask

  task automatic drain_all();
    core_we = 1'b0; core_re = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (q.size() == 0) break;
      cyc(1'b1);
    end
    chk("drained_empty", sb_empty, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; core_we = 1'b0; core_re = 1'b0; core_addr = '0; core_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk); #1;
    chk("rst_count", sb_count, 0);
    chk("rst_empty", sb_empty, 1);
    chk("rst_valid", mem_valid, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_rdata", core_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three stores queued, then reset mid-run.
    for (int i = 0; i < 3; i++) do_store(32'h10 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), -1, stalls);
    chk("queued_three", sb_count, 3);
    rst_n = 1'b0; #1;
    chk("rst2_count", sb_count, 0);
    chk("rst2_valid", mem_valid, 0);
    chk("rst2_empty", sb_empty, 1);
    q.delete(); prev_wr_wait = 0; prev_rd_wait = 0; rv_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; #1;
    chk("stale_stall", core_stall, 0);
    chk("stale_rdata", core_rdata, 0);
    @(negedge clk);
    do_load(32'h300, 0, 2, stalls);
    chk("miss_lat2_stall", stalls, 3);

    // Youngest match forwarding.
    do_store(32'h40, 32'hAAAA_0001, -1, stalls);
    do_store(32'h40, 32'hBBBB_0002, -1, stalls);
    do_load(32'h40, 0, 1, stalls);
    chk("hit_youngest", last_rdata, 32'hBBBB_0002);
    drain_all();

    // Fill, then a fifth store held until one pop.
    for (int i = 0; i < 4; i++) do_store(32'h500 + 32'(i * 4), 32'h5000_0000 + 32'(i), -1, stalls);
    chk("full_count", sb_count, 4);
    do_store(32'h520, 32'h5000_0004, 2, stalls);
    chk("full_stall_cycles", stalls, 3);
    chk("refill_count", sb_count, 4);
    drain_all();

    // Minimum-latency miss.
    mm[30'h20] = 32'h1234_5678;
    do_load(32'h80, 0, 1, stalls);
    chk("miss_min_stall", stalls, 2);
    chk("miss_min_data", last_rdata, 32'h1234_5678);

    // Miss arrives while a write is waiting on the port.
    do_store(32'h100, 32'h0100_0100, -1, stalls);
    idle(1, -1);
    do_load(32'h200, 2, 1, stalls);
    chk("wr_first_stall", stalls, 5);
    drain_all();

    // Eight back-to-back stores with memory always ready: pointers wrap twice.
    for (int i = 0; i < 8; i++) do_store(32'h700 + 32'(i * 4), 32'h7000_0000 + 32'(i), -2, stalls);
    drain_all();

    // Randomized mix over a small address pool so hits and misses both occur.
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if (r < 4)      do_store(a, $urandom, -3, stalls);
      else if (r < 7) do_load(a, -3, $urandom_range(1, 3), stalls);
      else            idle(1, -3);
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
